// File: rtl/traffic_sink.sv
// traffic_sink: NoC ejection endpoint. Consumes flits over a valid/ready
// handshake, rebuilds packets from the head/tail bits, checks framing,
// destination and VC consistency, and counts packets and flits. done is
// raised once the expected packet count, programmed by Init, has arrived.
//
// Optional feature macro: SINK_STALL_EN. When defined, an 8-bit LFSR adds
// pseudo-random backpressure on flit_ready.
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   op, data           command (5 = Init, data[31:22] = expected packet count)
//   node_id            endpoint address, compared against head flit_dst
//   flit_valid/ready   flit handshake
//   flit_head/tail     framing flags
//   flit_dst, flit_vc  destination (head flits only) and VC
//   done               expected packet count received
//   pkts_rcvd          completed packets
//   total_flits        accepted flits, saturating
//   last_pkt_len       length of the most recent completed packet
//   err_dest/seq/vc/extra  sticky error flags
module traffic_sink #(
  parameter int DEST_W = 14,
  parameter int VC_W   = 2,
  parameter int CNT_W  = 10,
  parameter int TOT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        op,
  input  logic [31:0]       data,
  input  logic [DEST_W-1:0] node_id,
  input  logic              flit_valid,
  output logic              flit_ready,
  input  logic              flit_head,
  input  logic              flit_tail,
  input  logic [DEST_W-1:0] flit_dst,
  input  logic [VC_W-1:0]   flit_vc,
  output logic              done,
  output logic [CNT_W-1:0]  pkts_rcvd,
  output logic [TOT_W-1:0]  total_flits,
  output logic [CNT_W-1:0]  last_pkt_len,
  output logic              err_dest,
  output logic              err_seq,
  output logic              err_vc,
  output logic              err_extra
);
  localparam logic [2:0]       OP_INIT = 3'd5;
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, WAIT_HEAD, IN_PKT, DONE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   expected_q, expected_d;
  logic [CNT_W-1:0]   pkts_q, pkts_d;
  logic [TOT_W-1:0]   tot_q, tot_d;
  logic [CNT_W-1:0]   last_len_q, last_len_d;
  logic [CNT_W-1:0]   cur_len_q, cur_len_d;
  logic [VC_W-1:0]    vc_q, vc_d;
  logic               e_dest_q, e_dest_d, e_seq_q, e_seq_d;
  logic               e_vc_q, e_vc_d, e_extra_q, e_extra_d;

  logic               init, stall, accept;
  logic               complete;
  logic [CNT_W-1:0]   done_len, pkts_inc;

  // Only data[31:22] carries the count.
  logic unused_data;
  assign unused_data = ^data[21:0];

  assign init = (op == OP_INIT);

`ifdef SINK_STALL_EN
  logic [7:0] lfsr_q, lfsr_d;
  always_comb begin
    // x^8 + x^6 + x^5 + x^4 + 1, shifting left.
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    if (init) lfsr_d = 8'hA5;
  end
  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= 8'hA5;
    else       lfsr_q <= lfsr_d;
  end
  assign stall = (lfsr_q[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  // Ready depends only on registered state and the command, never on valid.
  // Init cycles refuse flits so the counters clear cleanly.
  assign flit_ready = (state_q != IDLE) && !init && !stall;
  assign accept     = flit_valid && flit_ready;
  assign pkts_inc   = pkts_q + ONE;

  always_comb begin
    state_d    = state_q;
    expected_d = expected_q;
    pkts_d     = pkts_q;
    tot_d      = tot_q;
    last_len_d = last_len_q;
    cur_len_d  = cur_len_q;
    vc_d       = vc_q;
    e_dest_d   = e_dest_q;
    e_seq_d    = e_seq_q;
    e_vc_d     = e_vc_q;
    e_extra_d  = e_extra_q;
    complete   = 1'b0;
    done_len   = ONE;

    if (init) begin
      expected_d = CNT_W'(data[31:22]);
      pkts_d     = '0;
      tot_d      = '0;
      last_len_d = '0;
      cur_len_d  = '0;
      e_dest_d   = 1'b0;
      e_seq_d    = 1'b0;
      e_vc_d     = 1'b0;
      e_extra_d  = 1'b0;
      state_d    = (data[31:22] == '0) ? DONE : WAIT_HEAD;
    end else if (accept) begin
      tot_d = (&tot_q) ? tot_q : tot_q + TOT_W'(1);
      case (state_q)
        WAIT_HEAD, IN_PKT: begin
          if (state_q == IN_PKT && flit_vc != vc_q) e_vc_d = 1'b1;
          if (flit_head) begin
            // A head inside an open packet abandons it and restarts framing.
            if (state_q == IN_PKT) e_seq_d = 1'b1;
            if (flit_dst != node_id) e_dest_d = 1'b1;
            if (flit_tail) begin
              complete = 1'b1;
              done_len = ONE;
            end else begin
              cur_len_d = ONE;
              vc_d      = flit_vc;
              state_d   = IN_PKT;
            end
          end else if (state_q == WAIT_HEAD) begin
            e_seq_d = 1'b1;
          end else begin
            cur_len_d = cur_len_q + ONE;
            if (flit_tail) begin
              complete = 1'b1;
              done_len = cur_len_q + ONE;
            end
          end
          if (complete) begin
            pkts_d     = pkts_inc;
            last_len_d = done_len;
            state_d    = (pkts_inc == expected_q) ? DONE : WAIT_HEAD;
          end
        end
        DONE:    e_extra_d = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      expected_q <= '0;
      pkts_q     <= '0;
      tot_q      <= '0;
      last_len_q <= '0;
      cur_len_q  <= '0;
      vc_q       <= '0;
      e_dest_q   <= 1'b0;
      e_seq_q    <= 1'b0;
      e_vc_q     <= 1'b0;
      e_extra_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      expected_q <= expected_d;
      pkts_q     <= pkts_d;
      tot_q      <= tot_d;
      last_len_q <= last_len_d;
      cur_len_q  <= cur_len_d;
      vc_q       <= vc_d;
      e_dest_q   <= e_dest_d;
      e_seq_q    <= e_seq_d;
      e_vc_q     <= e_vc_d;
      e_extra_q  <= e_extra_d;
    end
  end

  assign done         = (state_q == DONE);
  assign pkts_rcvd    = pkts_q;
  assign total_flits  = tot_q;
  assign last_pkt_len = last_len_q;
  assign err_dest     = e_dest_q;
  assign err_seq      = e_seq_q;
  assign err_vc       = e_vc_q;
  assign err_extra    = e_extra_q;
endmodule

// File: tb/tb_traffic_sink.sv
module tb_traffic_sink;
  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  op;
  logic [31:0] data;
  logic [13:0] node_id;
  logic        flit_valid, flit_ready, flit_head, flit_tail;
  logic [13:0] flit_dst;
  logic [1:0]  flit_vc;
  logic        done, err_dest, err_seq, err_vc, err_extra;
  logic [9:0]  pkts_rcvd, last_pkt_len;
  logic [15:0] total_flits;

  traffic_sink dut (
    .clk(clk), .reset(reset), .op(op), .data(data), .node_id(node_id),
    .flit_valid(flit_valid), .flit_ready(flit_ready), .flit_head(flit_head),
    .flit_tail(flit_tail), .flit_dst(flit_dst), .flit_vc(flit_vc),
    .done(done), .pkts_rcvd(pkts_rcvd), .total_flits(total_flits),
    .last_pkt_len(last_pkt_len), .err_dest(err_dest), .err_seq(err_seq),
    .err_vc(err_vc), .err_extra(err_extra)
  );

  always #5 clk = ~clk;

  int nvec = 0, nerr = 0;
  bit acc_last;

  // Reference model: packet-level bookkeeping.
  bit         m_init, m_open, m_done;
  bit [9:0]   m_exp, m_pkts, m_last, m_len;
  int         m_tot;
  bit [1:0]   m_vc;
  bit         e_dest, e_seq, e_vc, e_extra;
  bit [7:0]   m_lfsr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic finish_pkt(input bit [9:0] n);
    m_open = 0;
    m_pkts = m_pkts + 10'd1;
    m_last = n;
    if (m_pkts == m_exp) m_done = 1;
  endtask

  task automatic step(input bit rst, input bit [2:0] o, input bit [31:0] d,
                      input bit v, input bit h, input bit t,
                      input bit [13:0] dst, input bit [1:0] vc);
    bit rdy, stall;
    @(negedge clk);
    reset = rst; op = o; data = d; flit_valid = v; flit_head = h;
    flit_tail = t; flit_dst = dst; flit_vc = vc;
    #1;
`ifdef SINK_STALL_EN
    stall = (m_lfsr[1:0] == 2'b00);
`else
    stall = 0;
`endif
    rdy = m_init && (o != 3'd5) && !stall;
    if (!rst) chk("ready", flit_ready, rdy);
    acc_last = v && rdy && !rst;
    @(posedge clk);
    if (rst) begin
      m_init = 0; m_open = 0; m_done = 0; m_exp = 0; m_pkts = 0; m_last = 0;
      m_len = 0; m_tot = 0; m_vc = 0;
      e_dest = 0; e_seq = 0; e_vc = 0; e_extra = 0; m_lfsr = 8'hA5;
    end else begin
      m_lfsr = (o == 3'd5) ? 8'hA5
             : {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
      if (o == 3'd5) begin
        m_init = 1; m_exp = d[31:22]; m_open = 0; m_done = (d[31:22] == 0);
        m_pkts = 0; m_last = 0; m_len = 0; m_tot = 0;
        e_dest = 0; e_seq = 0; e_vc = 0; e_extra = 0;
      end else if (acc_last) begin
        if (m_tot < 65535) m_tot++;
        if (m_done) e_extra = 1;
        else begin
          if (m_open && vc != m_vc) e_vc = 1;
          if (h) begin
            if (m_open) e_seq = 1;
            if (dst != node_id) e_dest = 1;
            if (t) finish_pkt(10'd1);
            else begin m_open = 1; m_len = 1; m_vc = vc; end
          end else if (!m_open) e_seq = 1;
          else begin
            m_len = m_len + 10'd1;
            if (t) finish_pkt(m_len);
          end
        end
      end
    end
    #1;
    chk("done", done, m_done);
    chk("pkts_rcvd", pkts_rcvd, m_pkts);
    chk("total_flits", total_flits, m_tot);
    chk("last_pkt_len", last_pkt_len, m_last);
    chk("err_dest", err_dest, e_dest);
    chk("err_seq", err_seq, e_seq);
    chk("err_vc", err_vc, e_vc);
    chk("err_extra", err_extra, e_extra);
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic do_init(input bit [9:0] n);
    step(0, 3'd5, {n, 22'd0}, 0, 0, 0, 0, 0);
  endtask
  // Present one flit until accepted (bounded).
  task automatic send(input bit h, input bit t, input bit [13:0] dst, input bit [1:0] vc);
    int n = 0;
    do begin
      step(0, 0, 0, 1, h, t, dst, vc);
      n++;
    end while (!acc_last && n < 32);
    chk("send_accepted", acc_last, 1);
  endtask

  initial begin
    node_id = 14'd5;
    do_reset(); do_reset();
    chk("rst_ready", flit_ready, 0);
    chk("rst_done", done, 0);

    // Three packets: 1, 4, 2 flits.
    do_init(3);
    send(1, 1, 5, 1);
    send(1, 0, 5, 1); send(0, 0, 5, 1); send(0, 0, 5, 1); send(0, 1, 5, 1);
    send(1, 0, 5, 1);
    chk("t1_notdone", done, 0);
    send(0, 1, 5, 1);
    chk("t1_done", done, 1);
    chk("t1_pkts", pkts_rcvd, 3);
    chk("t1_tot", total_flits, 7);
    chk("t1_last", last_pkt_len, 2);
    chk("t1_errs", {err_dest, err_seq, err_vc, err_extra}, 0);

    // Body without head.
    do_init(1);
    send(0, 0, 5, 0);
    chk("t2_seq", err_seq, 1);
    chk("t2_pkts", pkts_rcvd, 0);
    chk("t2_tot", total_flits, 1);
    send(1, 1, 5, 0);
    chk("t2_pkts1", pkts_rcvd, 1);
    chk("t2_done", done, 1);

    // Wrong destination, then VC change inside a packet.
    do_init(2);
    send(1, 0, 7, 1); send(0, 1, 7, 1);
    chk("t3_dest", err_dest, 1);
    chk("t3_pkts", pkts_rcvd, 1);
    send(1, 0, 5, 0); send(0, 1, 5, 2);
    chk("t3_vc", err_vc, 1);
    chk("t3_done", done, 1);

    // Reset mid-packet, then Init mid-packet.
    do_init(2);
    send(1, 0, 5, 1); send(0, 0, 5, 1); send(0, 0, 5, 1); send(0, 0, 5, 1);
    do_reset();
    chk("t4_ready", flit_ready, 0);
    chk("t4_outs", {done, pkts_rcvd, total_flits, last_pkt_len,
                    err_dest, err_seq, err_vc, err_extra}, 0);
    do_init(2);
    send(1, 1, 5, 1); send(1, 0, 5, 1); send(0, 0, 5, 1);
    do_init(2);
    chk("t4_init_outs", {done, pkts_rcvd, total_flits, last_pkt_len,
                         err_dest, err_seq, err_vc, err_extra}, 0);

    // Expected count of zero, then an extra flit.
    do_init(0);
    chk("t5_done", done, 1);
    send(1, 1, 5, 1);
    chk("t5_extra", err_extra, 1);
    chk("t5_pkts", pkts_rcvd, 0);
    chk("t5_tot", total_flits, 1);

    // Length counter wraps: 1030-flit packet reports 1030 mod 1024.
    do_init(1);
    send(1, 0, 5, 3);
    for (int i = 0; i < 1028; i++) send(0, 0, 5, 3);
    send(0, 1, 5, 3);
    chk("t6_last_wrap", last_pkt_len, 6);
    chk("t6_done", done, 1);

    // 100 single-flit packets with valid held high.
    do_init(100);
    for (int i = 0; i < 100; i++) send(1, 1, 5, 0);
    chk("t7_pkts", pkts_rcvd, 100);
    chk("t7_done", done, 1);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      int r;
      bit [2:0] o;
      r = $urandom_range(0, 99);
      o = 3'($urandom_range(0, 7));
      if (o == 3'd5) o = 3'd0;
      if (r < 1) do_reset();
      else if (r < 4 || !m_init) do_init(10'($urandom_range(0, 6)));
      else step(0, o, $urandom, ($urandom_range(0, 9) < 7),
                ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 4),
                ($urandom_range(0, 9) == 0) ? 14'($urandom) : 14'd5,
                ($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
